// File: rtl/dmem_ctrl_pkg.sv
// Shared types and helpers for the data-memory access controller.
package dmem_ctrl_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  // Controller states; 2-bit encoding shared with the top level.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  // Registered bus request payload, held stable for the whole access.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

  // Word accesses require the two low address bits to be zero.
  function automatic logic word_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb == 2'b00);
  endfunction

  // Timeout counter width: clog2(timeout+1), never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: turns the datapath's one-cycle load/store
// into a registered, ack-handshaked bus transaction and stalls the datapath
// until it completes. Misalignment and bus timeouts lock into a sticky error.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_ren,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              stall,
  output logic              bus_err,
  output logic              bus_cs,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack
);

  localparam int unsigned     CNT_W   = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT);
  localparam logic             TO_EN   = (TIMEOUT != 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  bus_req_t          req_q, req_d;
  logic              cs_q, cs_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              stall_c;
  logic              req_c;
  logic              aligned_c;

  // Request decode; a simultaneous read and write is treated as a write.
  always_comb begin
    req_c     = cpu_ren | cpu_wen;
    aligned_c = word_aligned(cpu_addr[1:0]);
  end

  // Next-state, next-register and combinational stall logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    cs_d    = cs_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    stall_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_c) begin
          stall_c = 1'b1;
          if (aligned_c) begin
            req_d.we    = cpu_wen;
            req_d.addr  = {cpu_addr[ADDR_W-1:2], 2'b00};
            req_d.wdata = cpu_wdata;
            cs_d        = 1'b1;
            cnt_d       = '0;
            state_d     = ST_BUSY;
          end else begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end
        end
      end

      ST_BUSY: begin
        stall_c = 1'b1;
        if (bus_ack) begin
          if (!req_q.we) begin
            rdata_d = bus_rdata;
          end
          cs_d    = 1'b0;
          state_d = ST_DONE;
        end else if (TO_EN && (cnt_q == CNT_LIM)) begin
          cs_d    = 1'b0;
          err_d   = 1'b1;
          state_d = ST_ERR;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      ST_ERR: begin
        stall_c = 1'b1;
        err_d   = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      cs_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      cs_q    <= cs_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Output mapping; stall is forced low while reset is held.
  always_comb begin
    stall     = stall_c & ~rst;
    bus_cs    = cs_q;
    bus_we    = req_q.we;
    bus_addr  = req_q.addr;
    bus_wdata = req_q.wdata;
    bus_err   = err_q;
    cpu_rdata = rdata_q;
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: table vectors, hand-written corner
// sequences and randomized accesses against a word-memory reference model.
module tb_dmem_ctrl;

  localparam int unsigned TO = 4;

  logic        clk;
  logic        rst;
  logic        cpu_ren;
  logic        cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        bus_err;
  logic        bus_cs;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  dmem_ctrl #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_ren   (cpu_ren),
    .cpu_wen   (cpu_wen),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .bus_err   (bus_err),
    .bus_cs    (bus_cs),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] ref_mem [64];
  logic [31:0] bus_mem [64];
  logic [31:0] exp_rdata;

  typedef struct {
    bit          we;
    bit          re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    int          lat;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    cpu_ren  = 1'b1;
    cpu_wen  = 1'b0;
    cpu_addr = 32'h0000_0008;
    bus_ack  = 1'b0;
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    step();
    rst     = 1'b0;
    cpu_ren = 1'b0;
    #1;
    check("rst_cs", 32'(bus_cs), 32'd0);
    check("rst_err", 32'(bus_err), 32'd0);
    check("rst_stall_after", 32'(stall), 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_we", 32'(bus_we), 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    check("rst_wdata", bus_wdata, 32'd0);
    exp_rdata = 32'd0;
  endtask

  // One access as seen from the datapath. An ack in BUSY cycle lat completes
  // if lat <= TO+1; otherwise the bus times out after TO+1 cycles of bus_cs.
  task automatic run_access(input bit we, input bit re, input logic [31:0] addr,
                            input logic [31:0] wdata, input int lat,
                            input logic [31:0] rd, input bit from_mem,
                            input logic [31:0] exp_rd);
    int k;
    bit acked;
    k     = 0;
    acked = 1'b0;
    cpu_wen   = we;
    cpu_ren   = re;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    #1;
    check("req_stall", 32'(stall), 32'd1);
    check("req_cs", 32'(bus_cs), 32'd0);
    if (addr[1:0] != 2'b00) begin
      for (int c = 0; c < 3; c++) begin
        step();
        check("mis_cs", 32'(bus_cs), 32'd0);
        check("mis_err", 32'(bus_err), 32'd1);
        check("mis_stall", 32'(stall), 32'd1);
      end
      check("mis_rdata", cpu_rdata, exp_rd);
      return;
    end
    while (!acked && k < int'(TO) + 1) begin
      step();
      k++;
      check("busy_cs", 32'(bus_cs), 32'd1);
      check("busy_we", 32'(bus_we), 32'(we));
      check("busy_addr", bus_addr, addr);
      if (we) check("busy_wdata", bus_wdata, wdata);
      check("busy_stall", 32'(stall), 32'd1);
      check("busy_err", 32'(bus_err), 32'd0);
      if (k == lat) begin
        bus_ack   = 1'b1;
        bus_rdata = from_mem ? bus_mem[bus_addr[7:2]] : rd;
        if (bus_we) bus_mem[bus_addr[7:2]] = bus_wdata;
        acked = 1'b1;
      end
    end
    step();
    bus_ack   = 1'b0;
    bus_rdata = $urandom;
    if (acked) begin
      check("done_stall", 32'(stall), 32'd0);
      check("done_cs", 32'(bus_cs), 32'd0);
      check("done_err", 32'(bus_err), 32'd0);
      check("done_rdata", cpu_rdata, exp_rd);
      if (we) ref_mem[addr[7:2]] = wdata;
      step();
      cpu_ren = 1'b0;
      cpu_wen = 1'b0;
      #1;
      check("idle_stall", 32'(stall), 32'd0);
      check("idle_cs", 32'(bus_cs), 32'd0);
      check("idle_rdata", cpu_rdata, exp_rd);
    end else begin
      check("to_cs", 32'(bus_cs), 32'd0);
      check("to_err", 32'(bus_err), 32'd1);
      check("to_stall", 32'(stall), 32'd1);
      bus_ack = 1'b1;
      step();
      bus_ack = 1'b0;
      check("to_hold_err", 32'(bus_err), 32'd1);
      check("to_hold_cs", 32'(bus_cs), 32'd0);
      check("to_hold_stall", 32'(stall), 32'd1);
      check("to_rdata", cpu_rdata, exp_rd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    cpu_ren   = 1'b0;
    cpu_wen   = 1'b0;
    cpu_addr  = 32'd0;
    cpu_wdata = 32'd0;
    bus_rdata = 32'd0;
    bus_ack   = 1'b0;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = $urandom;
      bus_mem[i] = ref_mem[i];
    end

    do_reset();

    // we, re, addr, wdata, bus rdata, ack latency, expected cpu_rdata
    vecs[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,          32'hDEAD_BEEF, 3, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0020, 32'h1234_5678,  32'hFFFF_FFFF, 1, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0040, 32'hA5A5_A5A5,  32'h1111_1111, 2, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_0044, 32'h0,          32'h0BAD_F00D, 5, 32'h0BAD_F00D};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_0012, 32'h0,          32'h0,         1, 32'h0BAD_F00D};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_004C, 32'h5555_AAAA,  32'h0,         9, 32'h0};

    for (int i = 0; i < 6; i++) begin
      run_access(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, vecs[i].lat,
                 vecs[i].rd, 1'b0, vecs[i].exp_rd);
      if (vecs[i].addr[1:0] != 2'b00 || vecs[i].lat > int'(TO) + 1) do_reset();
      else exp_rdata = vecs[i].exp_rd;
    end

    // Stray ack in IDLE after recovering from a timeout.
    bus_ack   = 1'b1;
    bus_rdata = 32'h7777_7777;
    step();
    bus_ack = 1'b0;
    check("stray_cs", 32'(bus_cs), 32'd0);
    check("stray_stall", 32'(stall), 32'd0);
    check("stray_rdata", cpu_rdata, 32'd0);
    check("stray_err", 32'(bus_err), 32'd0);

    // Load a nonzero value, then reset mid-BUSY and deliver a late ack.
    run_access(1'b0, 1'b1, 32'h0000_0030, 32'h0, 2, 32'h0000_0077, 1'b0, 32'h0000_0077);
    cpu_ren  = 1'b1;
    cpu_addr = 32'h0000_0034;
    step();
    step();
    check("mid_cs", 32'(bus_cs), 32'd1);
    rst = 1'b1;
    step();
    rst       = 1'b0;
    cpu_ren   = 1'b0;
    bus_ack   = 1'b1;
    bus_rdata = 32'hCAFE_F00D;
    #1;
    check("abort_cs", 32'(bus_cs), 32'd0);
    check("abort_stall", 32'(stall), 32'd0);
    check("abort_rdata", cpu_rdata, 32'd0);
    step();
    bus_ack = 1'b0;
    check("late_ack_cs", 32'(bus_cs), 32'd0);
    check("late_ack_rdata", cpu_rdata, 32'd0);
    check("late_ack_stall", 32'(stall), 32'd0);
    exp_rdata = 32'd0;
    run_access(1'b0, 1'b1, 32'h0000_0034, 32'h0, 1, 32'h0000_0099, 1'b0, 32'h0000_0099);
    exp_rdata = 32'h0000_0099;

    // Randomized accesses against the word-memory model.
    for (int i = 0; i < 40; i++) begin
      bit          we;
      bit          re;
      bit          mis;
      bit          err;
      int          lat;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] er;
      we  = 1'($urandom_range(0, 1));
      re  = we ? 1'($urandom_range(0, 1)) : 1'b1;
      mis = ($urandom_range(0, 9) == 0);
      a   = {24'h0, 6'($urandom_range(0, 63)), mis ? 2'($urandom_range(1, 3)) : 2'b00};
      wd  = $urandom;
      lat = int'($urandom_range(1, TO + 2));
      err = mis || (lat > int'(TO) + 1);
      er  = (err || we) ? exp_rdata : ref_mem[a[7:2]];
      run_access(we, re, a, wd, lat, 32'h0, 1'b1, er);
      if (err) do_reset();
      else exp_rdata = er;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
